sobel_scan_ctrl: RTL and testbench
==================================

# sobel_scan_ctrl

Frame sequencer for the Sobel edge-detection datapath. It drives raster-order reads from the input image memory, produces the shift and window-valid strobes for the line-buffer and Sobel core, and generates write enables and addresses for the output memory. It also handles start/done and the total cycle count. It sits between the top-level system control and the image memory, line buffer, Sobel core and output memory.

## Interface
- WIDTH, 240, image width in pixels (≥3)
- HEIGHT, 240, image height in pixels (≥3)
- RD_LAT, 1, input memory read latency in cycles (≥1)
- SOBEL_LAT, 2, cycles from window-valid to magnitude ready at the core output
- ADDR_W, $clog2(WIDTH*HEIGHT), address width for both memories

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a frame; sampled in IDLE and DONE only
- hold  in  1  suppresses read issue this cycle (input-memory arbitration loss)
- in_rd_en  out  1  input memory read strobe
- in_rd_addr  out  ADDR_W  raster read address
- win_shift  out  1  read data valid this cycle; line buffer and window shift
- win_valid  out  1  the shifted-in pixel completes a full 3×3 window
- out_wr_en  out  1  output memory write strobe
- out_wr_addr  out  ADDR_W  output address, 0..OUTTOT-1
- busy  out  1  high in SCAN and DRAIN
- done  out  1  frame complete; held until the next start
- total_cycles_out  out  32  cycles spent in SCAN plus DRAIN for the last frame

## Operation
- TOTAL = WIDTH·HEIGHT; OUTTOT = (WIDTH-2)·(HEIGHT-2).
- FSM states: IDLE → SCAN on start. SCAN → DRAIN after the read with index TOTAL-1 issues. DRAIN → DONE when the delay pipe is empty. DONE → SCAN on start.
- SCAN:
  - in_rd_en = !hold.
  - The read index counter n, the row counter r (0..HEIGHT-1) and the column counter c (0..WIDTH-1) advance only on issued reads. c wraps to 0 at WIDTH-1 and r increments.
  - in_rd_addr = n.
- Each issued read launches a token {interior = (r≥2 && c≥2)} into an RD_LAT-deep delay line.
  - At the delay line's output: win_shift = token valid; win_valid = token valid && interior.
  - win_valid feeds a SOBEL_LAT-deep delay line whose output is out_wr_en.
- Hold inserts bubbles only. The delay lines never freeze.
- out_wr_addr:
  - A counter reset to 0 at frame start.
  - Its value is presented alongside out_wr_en and increments after each write.
  - It never exceeds OUTTOT-1.
- hold is ignored outside SCAN. start is ignored in SCAN and DRAIN.
- Cycle counter:
  - Cleared on entry to SCAN.
  - Increments every SCAN and DRAIN cycle, including hold cycles.
  - Frozen in IDLE and DONE.
  - total_cycles_out shows the counter value directly.
- Reset (any state, mid-frame included): state = IDLE. All outputs are 0, including total_cycles_out. Counters and delay lines are cleared. Pending tokens are discarded.

## Timing
- Cycle 0 is the first SCAN cycle. start is sampled high on the edge ending the previous cycle.
- With no hold:
  - The read of index p is issued in cycle p.
  - win_shift for index p occurs in cycle p+RD_LAT.
  - out_wr_en for index p occurs in cycle p+RD_LAT+SOBEL_LAT.
- Defaults (WIDTH = HEIGHT = 240, RD_LAT = 1, SOBEL_LAT = 2):
  - The first write occurs at cycle 482+3 = 485 with address 0.
  - The last read occurs at cycle 57599; the last write at cycle 57602 with address 56643.
  - DRAIN spans cycles 57600–57602.
  - done=1 and busy=0 from cycle 57603; total_cycles_out = 57603.
- Each hold cycle during SCAN delays all subsequent events and total_cycles_out by exactly 1.
- done falls in the first cycle of a new SCAN. total_cycles_out reads 0 in that cycle.

## Structure
- Package sobel_pkg:
  - state enum {IDLE, SCAN, DRAIN, DONE}.
  - Default WIDTH/HEIGHT constants.
  - The OUTW/OUTH/OUTTOT derivation functions.
- Sub-module sobel_valid_pipe:
  - Parameterized DEPTH delay line of 1-bit valid, with synchronous active-low clear.
  - Instantiated twice: once with DEPTH = RD_LAT, once with DEPTH = SOBEL_LAT.
- The top module contains the FSM, the raster/row/column counters, the output address counter and the cycle counter.

## Test plan
- Default parameters, start pulsed once, hold=0:
  - 57600 reads with addresses 0..57599.
  - 56644 writes; the first write at cycle 485 with address 0.
  - done at cycle 57603; total_cycles_out = 57603.
- WIDTH = HEIGHT = 4:
  - win_valid only for indices 10, 11, 14, 15.
  - out_wr_addr 0, 1, 2, 3.
  - total_cycles_out = 19.
- hold pattern of 1 cycle on every 10th SCAN cycle, 4×4 image:
  - Read and write sequences identical to the no-hold case, with bubbles.
  - total_cycles_out = 19 + (number of hold cycles).
- rst_n low for 1 cycle at SCAN cycle 300:
  - Next cycle: IDLE, all outputs 0, no further writes.
  - A later start yields a clean full frame.
- start held high in SCAN and DRAIN: ignored. start in DONE: restart, done low next cycle, out_wr_addr restarts at 0.
- WIDTH = HEIGHT = 3, RD_LAT = 2: exactly one write, address 0, at cycle 8+2+2 = 12; total_cycles_out = 13.

Source files
------------

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared state encoding and frame geometry helpers for the Sobel scan controller
package sobel_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 240;

  // The 3x3 window loses one pixel on each border, so each output dimension is two smaller.
  function automatic int out_w(input int w);
    return w - 2;
  endfunction

  function automatic int out_h(input int h);
    return h - 2;
  endfunction

  function automatic int out_tot(input int w, input int h);
    return out_w(w) * out_h(h);
  endfunction

endpackage

// File: rtl/sobel_valid_pipe.sv
// rtl/sobel_valid_pipe.sv - fixed-depth token delay line; bit 0 of each token is its valid flag
module sobel_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         clr_n_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o,
  output logic         pend_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[DEPTH-1];

  // Valid tokens that will still be inside the line after this cycle's shift.
  always_comb begin
    pend_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pend_o = pend_o | stage_q[i][0];
  end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// rtl/sobel_scan_ctrl.sv - raster read sequencer, window strobes, output write addressing and frame timing
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int RD_LAT    = 1,
  parameter int SOBEL_LAT = 2,
  parameter int ADDR_W    = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic              win_shift,
  output logic              win_valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       total_cycles_out
);

  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int OUTTOT = out_tot(WIDTH, HEIGHT);
  localparam int CW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT);

  localparam logic [ADDR_W-1:0] LAST_N  = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_WA = ADDR_W'(OUTTOT - 1);
  localparam logic [CW-1:0]     LAST_C  = CW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       cyc_q, cyc_d;

  logic issue, interior, tok_v, tok_int, rd_pend, sob_pend, drain_empty;

  assign issue    = (state_q == SCAN) && !hold;
  assign interior = (r_q >= RW'(2)) && (c_q >= CW'(2));

  sobel_valid_pipe #(.DEPTH(RD_LAT), .W(2)) u_rd_pipe (
    .clk_i   (clk),
    .clr_n_i (rst_n),
    .in_i    ({issue & interior, issue}),
    .out_o   ({tok_int, tok_v}),
    .pend_o  (rd_pend)
  );

  assign win_shift = tok_v;
  assign win_valid = tok_v & tok_int;

  sobel_valid_pipe #(.DEPTH(SOBEL_LAT), .W(1)) u_sobel_pipe (
    .clk_i   (clk),
    .clr_n_i (rst_n),
    .in_i    (win_valid),
    .out_o   (out_wr_en),
    .pend_o  (sob_pend)
  );

  // The token on out_wr_en this cycle is the last one if nothing sits behind it.
  assign drain_empty = !rd_pend && !tok_v && !sob_pend;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r_d     = r_q;
    c_d     = c_q;
    wa_d    = wa_q;
    cyc_d   = cyc_q;

    if (state_q == SCAN || state_q == DRAIN) cyc_d = cyc_q + 32'd1;
    if (out_wr_en && wa_q != LAST_WA) wa_d = wa_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SCAN;
          n_d     = '0;
          r_d     = '0;
          c_d     = '0;
          wa_d    = '0;
          cyc_d   = '0;
        end
      end
      SCAN: begin
        if (issue) begin
          n_d = n_q + 1'b1;
          if (c_q == LAST_C) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
          if (n_q == LAST_N) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      wa_q    <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      r_q     <= r_d;
      c_q     <= c_d;
      wa_q    <= wa_d;
      cyc_q   <= cyc_d;
    end
  end

  assign in_rd_en         = issue;
  assign in_rd_addr       = (state_q == SCAN) ? n_q : '0;
  assign out_wr_addr      = wa_q;
  assign busy             = (state_q == SCAN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign total_cycles_out = cyc_q;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// tb/tb_sobel_scan_ctrl.sv - scoreboard bench for sobel_scan_ctrl on 240x240, 4x4 and 3x3 frames
module tb_sobel_scan_ctrl;

  typedef struct packed {
    int v;
    int cyc;
  } ent_t;

  // Queue index = dut*4 + kind; kind 0 read, 1 shift, 2 window valid, 3 write.
  ent_t sbq [12][$];

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;
  int base [3];
  int nrd_a  = 0;
  int nwr_a  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  logic        rst_n_a, start_a, hold_a, rd_en_a, sh_a, wv_a, we_a, busy_a, done_a;
  logic [15:0] rd_addr_a, wa_a;
  logic [31:0] tot_a;
  logic        rst_n_b, start_b, hold_b, rd_en_b, sh_b, wv_b, we_b, busy_b, done_b;
  logic [3:0]  rd_addr_b, wa_b;
  logic [31:0] tot_b;
  logic        rst_n_c, start_c, hold_c, rd_en_c, sh_c, wv_c, we_c, busy_c, done_c;
  logic [3:0]  rd_addr_c, wa_c;
  logic [31:0] tot_c;

  sobel_scan_ctrl u_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .hold(hold_a),
    .in_rd_en(rd_en_a), .in_rd_addr(rd_addr_a), .win_shift(sh_a), .win_valid(wv_a),
    .out_wr_en(we_a), .out_wr_addr(wa_a), .busy(busy_a), .done(done_a),
    .total_cycles_out(tot_a)
  );

  sobel_scan_ctrl #(.WIDTH(4), .HEIGHT(4)) u_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .hold(hold_b),
    .in_rd_en(rd_en_b), .in_rd_addr(rd_addr_b), .win_shift(sh_b), .win_valid(wv_b),
    .out_wr_en(we_b), .out_wr_addr(wa_b), .busy(busy_b), .done(done_b),
    .total_cycles_out(tot_b)
  );

  sobel_scan_ctrl #(.WIDTH(3), .HEIGHT(3), .RD_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n_c), .start(start_c), .hold(hold_c),
    .in_rd_en(rd_en_c), .in_rd_addr(rd_addr_c), .win_shift(sh_c), .win_valid(wv_c),
    .out_wr_en(we_c), .out_wr_addr(wa_c), .busy(busy_c), .done(done_c),
    .total_cycles_out(tot_c)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input int k, input int v, input int c);
    ent_t e;
    e.v   = v;
    e.cyc = c;
    sbq[d*4+k].push_back(e);
  endtask

  function automatic int qleft(input int d);
    return sbq[d*4].size() + sbq[d*4+1].size() + sbq[d*4+2].size() + sbq[d*4+3].size();
  endfunction

  task automatic evt(input string nm, input int d, input int k, input int v);
    int   rel;
    ent_t e;
    rel = gcyc - base[d];
    checks++;
    if (sbq[d*4+k].size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event value %0d at cycle %0d", nm, v, rel);
    end else begin
      e = sbq[d*4+k].pop_front();
      if (e.v != v || e.cyc != rel) begin
        errors++;
        $display("FAIL %s: got value %0d at cycle %0d expected value %0d at cycle %0d",
                 nm, v, rel, e.v, e.cyc);
      end
    end
  endtask

  // Expected events for a frame: reads in raster order, hold bubbles every hper-th SCAN cycle.
  task automatic gen(input int d, input int w, input int rdl, input int sbl,
                     input int hper, input int nreads);
    int t = 0, p = 0, k = 0;
    while (p < nreads) begin
      if (hper > 0 && (t % hper) == hper - 1) begin
        t++;
      end else begin
        push(d, 0, p, t);
        push(d, 1, 0, t + rdl);
        if ((p / w) >= 2 && (p % w) >= 2) begin
          push(d, 2, 0, t + rdl);
          push(d, 3, k, t + rdl + sbl);
          k++;
        end
        p++;
        t++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rd_en_a) begin evt("a_rd", 0, 0, int'(rd_addr_a)); nrd_a++; end
    if (sh_a)    evt("a_shift", 0, 1, 0);
    if (wv_a)    evt("a_wv", 0, 2, 0);
    if (we_a)    begin evt("a_wr", 0, 3, int'(wa_a)); nwr_a++; end
  end

  always @(negedge clk) begin
    if (rd_en_b) evt("b_rd", 1, 0, int'(rd_addr_b));
    if (sh_b)    evt("b_shift", 1, 1, 0);
    if (wv_b)    evt("b_wv", 1, 2, 0);
    if (we_b)    evt("b_wr", 1, 3, int'(wa_b));
  end

  always @(negedge clk) begin
    if (rd_en_c) evt("c_rd", 2, 0, int'(rd_addr_c));
    if (sh_c)    evt("c_shift", 2, 1, 0);
    if (wv_c)    evt("c_wv", 2, 2, 0);
    if (we_c)    evt("c_wr", 2, 3, int'(wa_c));
  end

  initial begin
    rst_n_a = 1'b0; start_a = 1'b0; hold_a = 1'b0;
    rst_n_b = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    rst_n_c = 1'b0; start_c = 1'b0; hold_c = 1'b0;
    base[0] = 0; base[1] = 0; base[2] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_strobes", {rd_en_a, sh_a, wv_a, we_a, busy_a, done_a}, 0);
    chk("a_rst_addrs", rd_addr_a | wa_a, 0);
    chk("a_rst_total", tot_a, 0);
    chk("b_rst_strobes", {rd_en_b, sh_b, wv_b, we_b, busy_b, done_b}, 0);
    chk("b_rst_addrs", rd_addr_b | wa_b, 0);
    chk("b_rst_total", tot_b, 0);
    chk("c_rst_strobes", {rd_en_c, sh_c, wv_c, we_c, busy_c, done_c}, 0);
    chk("c_rst_total", tot_c, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;

    fork
      begin : dut_a
        int n0rd, n0wr;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 base[0] = gcyc; start_a = 1'b0;
        gen(0, 240, 1, 2, 0, 301);
        while (gcyc - base[0] < 300) begin @(posedge clk); #1; end
        rst_n_a = 1'b0;
        @(posedge clk); #1 rst_n_a = 1'b1;
        chk("a_abort_strobes", {rd_en_a, sh_a, wv_a, we_a, busy_a, done_a}, 0);
        chk("a_abort_addrs", rd_addr_a | wa_a, 0);
        chk("a_abort_total", tot_a, 0);
        chk("a_abort_pending", sbq[1].size(), 1);
        sbq[1].delete();
        repeat (20) @(posedge clk);
        #1;
        chk("a_abort_left", qleft(0), 0);
        chk("a_abort_idle", {busy_a, done_a}, 0);
        n0rd = nrd_a;
        n0wr = nwr_a;
        start_a = 1'b1;
        @(posedge clk); #1 base[0] = gcyc; start_a = 1'b0;
        gen(0, 240, 1, 2, 0, 57600);
        for (int i = 0; i < 60000 && !done_a; i++) begin @(posedge clk); #1; end
        chk("a_done", done_a, 1);
        chk("a_done_cycle", gcyc - base[0], 57603);
        chk("a_total", tot_a, 57603);
        chk("a_busy_done", busy_a, 0);
        chk("a_last_wr_addr", wa_a, 56643);
        chk("a_read_count", nrd_a - n0rd, 57600);
        chk("a_write_count", nwr_a - n0wr, 56644);
        chk("a_left", qleft(0), 0);
      end
      begin : dut_b
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 base[1] = gcyc; start_b = 1'b0;
        gen(1, 4, 1, 2, 0, 16);
        for (int i = 0; i < 100 && !done_b; i++) begin @(posedge clk); #1; end
        chk("b1_done", done_b, 1);
        chk("b1_done_cycle", gcyc - base[1], 19);
        chk("b1_total", tot_b, 19);
        chk("b1_busy", busy_b, 0);
        chk("b1_wr_addr_sat", wa_b, 3);
        chk("b1_left", qleft(1), 0);
        // start stays high through the whole held frame and into its DONE state.
        start_b = 1'b1;
        @(posedge clk); #1 base[1] = gcyc; hold_b = 1'b0;
        gen(1, 4, 1, 2, 10, 16);
        for (int i = 0; i < 100 && !done_b; i++) begin
          @(posedge clk); #1;
          hold_b = ((gcyc - base[1]) % 10) == 9;
        end
        chk("b2_done", done_b, 1);
        chk("b2_done_cycle", gcyc - base[1], 20);
        chk("b2_total", tot_b, 20);
        chk("b2_left", qleft(1), 0);
        @(posedge clk); #1 base[1] = gcyc; start_b = 1'b0; hold_b = 1'b0;
        chk("b3_restart_done", done_b, 0);
        chk("b3_restart_busy", busy_b, 1);
        chk("b3_restart_total", tot_b, 0);
        chk("b3_restart_wr_addr", wa_b, 0);
        gen(1, 4, 1, 2, 0, 16);
        for (int i = 0; i < 100 && !done_b; i++) begin @(posedge clk); #1; end
        chk("b3_done", done_b, 1);
        chk("b3_total", tot_b, 19);
        chk("b3_left", qleft(1), 0);
      end
      begin : dut_c
        @(posedge clk); #1 start_c = 1'b1;
        @(posedge clk); #1 base[2] = gcyc; start_c = 1'b0;
        gen(2, 3, 2, 2, 0, 9);
        for (int i = 0; i < 100 && !done_c; i++) begin @(posedge clk); #1; end
        chk("c_done", done_c, 1);
        chk("c_done_cycle", gcyc - base[2], 13);
        chk("c_total", tot_c, 13);
        chk("c_wr_addr", wa_c, 0);
        chk("c_left", qleft(2), 0);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
